reg_file_mp: RTL

//  Parametrised multi-read-port register file for the single-cycle datapath, next generation
//  of the 2R/1W file. Adds configurable width/depth/read-port count, a hardware clear

---
 rtl/rf_pkg.sv | 7 +
 rtl/rf_clear_seq.sv | 33 +++
 rtl/reg_file_mp.sv | 56 +++++
 3 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared types and helpers for the multi-port register file.
package rf_pkg;
  typedef enum logic {RF_CLEAR, RF_IDLE} rf_state_t;
  function automatic int rf_depth(input int addr_w);
    return 1 << addr_w;
  endfunction
endpackage

// File: rtl/rf_clear_seq.sv
// rf_clear_seq: walks every entry after reset or on request, emitting one zero-write per cycle.
import rf_pkg::*;
module rf_clear_seq #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(rf_depth(ADDR_W) - 1);
  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;
  always_comb begin
    state_d = (state_q == RF_CLEAR) ? ((!clear_req && count_q == LAST) ? RF_IDLE : RF_CLEAR)
                                    : (clear_req ? RF_CLEAR : RF_IDLE);
    count_d = (state_q == RF_CLEAR && !clear_req && count_q != LAST) ? count_q + 1'b1 : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RF_CLEAR;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end
  assign busy     = (state_q == RF_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = count_q;
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised NUM_RD-read / 1-write register file with hardware clear.
// Define RF_BYPASS_EN to forward same-cycle write data to matching read ports.
import rf_pkg::*;
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_req,
  output logic                     busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_drop,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data
);
  localparam int DEPTH = rf_depth(ADDR_W);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              clr_we, we, wr_zero, wr_drop_q, wr_drop_d;
  logic [ADDR_W-1:0] clr_addr, waddr;
  logic [DATA_W-1:0] wdata;
  rf_clear_seq #(.ADDR_W(ADDR_W)) u_clr (
    .clk(clk), .rst(rst), .clear_req(clear_req),
    .busy(busy), .clr_we(clr_we), .clr_addr(clr_addr)
  );
  always_comb begin
    wr_zero   = (ZERO_REG != 0) && (wr_addr == '0);
    we        = clr_we | (wr_en & ~wr_zero);
    waddr     = clr_we ? clr_addr : wr_addr;
    wdata     = clr_we ? '0 : wr_data;
    wr_drop_d = wr_en & busy;
  end
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_drop_q <= 1'b0;
    else     wr_drop_q <= wr_drop_d;
  end
  assign wr_drop = wr_drop_q;
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              zero_r;
    assign a      = rd_addr[i*ADDR_W +: ADDR_W];
    assign zero_r = busy || ((ZERO_REG != 0) && (a == '0));
`ifdef RF_BYPASS_EN
    assign rd_data[i*DATA_W +: DATA_W] = zero_r ? '0 : (wr_en && a == wr_addr) ? wr_data : mem_q[a];
`else
    assign rd_data[i*DATA_W +: DATA_W] = zero_r ? '0 : mem_q[a];
`endif
  end
endmodule
